reg_wb_buffer: RTL and testbench

- Write-back buffer that sits between the multi-cycle result producers (load unit, multiplier) and the 32x32 register file write port.
- Accepts register-write requests through a valid/ready handshake and queues them in order.
- Retires at most one request per cycle into the register file as a reg_write / write_reg / write_data strobe.
- Provides two forwarding lookups, so operand reads see queued writes that have not yet retired.

---
 rtl/reg_wb_buffer_pkg.sv | 18 +
 rtl/reg_wb_buffer_fwd_match.sv | 42 ++++
 rtl/reg_wb_buffer.sv | 144 ++++++++++++++
 tb/tb_reg_wb_buffer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_wb_buffer_pkg.sv
// Shared definitions for the register write-back buffer.
//   REG_ADDR_W / REG_DATA_W : register file address and data widths
//   ZERO_REG               : hard-wired zero register, never stored or forwarded
//   wb_entry_t             : one queued register write {valid, reg_addr, data}
package reg_wb_buffer_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] reg_addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/reg_wb_buffer_fwd_match.sv
// Youngest-match forwarding search for one operand read port.
// Ports:
//   entry_valid/entry_reg/entry_data : flattened buffer contents, indexed by slot
//   tail                             : next write slot; tail-1 is the youngest entry
//   rd_reg / rf_data                 : operand address and register file read data
//   fwd_data                         : operand value with queued writes applied
module wb_fwd_match
    import reg_wb_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int PTR_W  = 2
) (
    input  logic [DEPTH-1:0]             entry_valid,
    input  logic [DEPTH-1:0][ADDR_W-1:0] entry_reg,
    input  logic [DEPTH-1:0][DATA_W-1:0] entry_data,
    input  logic [PTR_W-1:0]             tail,
    input  logic [ADDR_W-1:0]            rd_reg,
    input  logic [DATA_W-1:0]            rf_data,
    output logic [DATA_W-1:0]            fwd_data
);

    logic [PTR_W-1:0] slot;

    // Walk from oldest (tail-DEPTH) to youngest (tail-1); later hits override,
    // so the entry closest to tail wins.
    always_comb begin
        fwd_data = rf_data;
        slot     = '0;
        for (int i = DEPTH; i >= 1; i--) begin
            slot = tail - PTR_W'(i);
            if (entry_valid[slot] && (entry_reg[slot] == rd_reg)) begin
                fwd_data = entry_data[slot];
            end
        end
        if (rd_reg == ZERO_REG) begin
            fwd_data = '0;
        end
    end

endmodule

// File: rtl/reg_wb_buffer.sv
// In-order write-back buffer between multi-cycle result producers and the
// register file write port, with two forwarding lookups for operand reads.
// Ports:
//   clk, rstn                          : clock, asynchronous active-low reset
//   flush                              : synchronous clear of all queued entries
//   enq_valid/enq_ready/enq_reg/enq_data : write request handshake
//   drain_en                           : register file write port available
//   reg_write/write_reg/write_data     : register file write strobe
//   rd_reg_k/rf_data_k/fwd_data_k      : operand lookups, k = 1, 2
//   count                              : number of valid queued entries
module reg_wb_buffer
    import reg_wb_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [ADDR_W-1:0] enq_reg,
    input  logic [DATA_W-1:0] enq_data,
    input  logic              drain_en,
    output logic              reg_write,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] rd_reg_1,
    input  logic [DATA_W-1:0] rf_data_1,
    output logic [DATA_W-1:0] fwd_data_1,
    input  logic [ADDR_W-1:0] rd_reg_2,
    input  logic [DATA_W-1:0] rf_data_2,
    output logic [DATA_W-1:0] fwd_data_2,
    output logic [ADDR_W:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    wb_entry_t               entries [DEPTH];
    logic [PTR_W-1:0]        head;
    logic [PTR_W-1:0]        tail;
    logic [ADDR_W:0]         count_q;

    logic                    full;
    logic                    empty;
    logic                    enq_fire;
    logic                    store;
    logic                    drain;

    logic [DEPTH-1:0]             ent_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] ent_reg;
    logic [DEPTH-1:0][DATA_W-1:0] ent_data;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // Ready depends only on registered occupancy; a same-cycle drain does not
    // open a slot for the current request.
    assign enq_ready = !full;
    assign enq_fire  = enq_valid && enq_ready && !flush;
    // Writes to the zero register complete the handshake but are dropped.
    assign store     = enq_fire && (enq_reg != ZERO_REG);

    assign reg_write  = !empty && drain_en && !flush;
    assign drain      = reg_write;
    assign write_reg  = empty ? '0 : entries[head].reg_addr;
    assign write_data = empty ? '0 : entries[head].data;
    assign count      = count_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].valid <= 1'b0;
            end
        end else begin
            // store and drain never target the same slot: store needs !full,
            // drain needs !empty, so head==tail excludes one of them.
            if (store) begin
                entries[tail].valid    <= 1'b1;
                entries[tail].reg_addr <= enq_reg;
                entries[tail].data     <= enq_data;
                tail                   <= tail + PTR_W'(1);
            end
            if (drain) begin
                entries[head].valid <= 1'b0;
                head                <= head + PTR_W'(1);
            end
            case ({store, drain})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_flat
        assign ent_valid[k] = entries[k].valid;
        assign ent_reg[k]   = entries[k].reg_addr;
        assign ent_data[k]  = entries[k].data;
    end

    wb_fwd_match #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .PTR_W (PTR_W)
    ) u_fwd_1 (
        .entry_valid(ent_valid),
        .entry_reg  (ent_reg),
        .entry_data (ent_data),
        .tail       (tail),
        .rd_reg     (rd_reg_1),
        .rf_data    (rf_data_1),
        .fwd_data   (fwd_data_1)
    );

    wb_fwd_match #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .PTR_W (PTR_W)
    ) u_fwd_2 (
        .entry_valid(ent_valid),
        .entry_reg  (ent_reg),
        .entry_data (ent_data),
        .tail       (tail),
        .rd_reg     (rd_reg_2),
        .rf_data    (rf_data_2),
        .fwd_data   (fwd_data_2)
    );

endmodule

// File: tb/tb_reg_wb_buffer.sv
module tb_reg_wb_buffer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        enq_valid;
    logic        enq_ready;
    logic [4:0]  enq_reg;
    logic [31:0] enq_data;
    logic        drain_en;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [4:0]  rd_reg_1;
    logic [31:0] rf_data_1;
    logic [31:0] fwd_data_1;
    logic [4:0]  rd_reg_2;
    logic [31:0] rf_data_2;
    logic [31:0] fwd_data_2;
    logic [5:0]  count;

    int checks = 0;
    int errors = 0;

    logic [36:0] sb_q [$];   // {reg, data} expected on the register file port

    reg_wb_buffer dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .enq_reg   (enq_reg),
        .enq_data  (enq_data),
        .drain_en  (drain_en),
        .reg_write (reg_write),
        .write_reg (write_reg),
        .write_data(write_data),
        .rd_reg_1  (rd_reg_1),
        .rf_data_1 (rf_data_1),
        .fwd_data_1(fwd_data_1),
        .rd_reg_2  (rd_reg_2),
        .rf_data_2 (rf_data_2),
        .fwd_data_2(fwd_data_2),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Commits are sampled mid-cycle; inputs only move just after posedge.
    always @(negedge clk) begin
        if (rstn && reg_write) begin
            if (sb_q.size() == 0) begin
                chk("spurious_write", reg_write, 1'b0);
            end else begin
                logic [36:0] e;
                e = sb_q.pop_front();
                chk("write_reg", write_reg, e[36:32]);
                chk("write_data", write_data, e[31:0]);
            end
        end
    end

    task automatic enq(input logic [4:0] r, input logic [31:0] d);
        int n;
        n = 0;
        enq_valid = 1'b1;
        enq_reg   = r;
        enq_data  = d;
        while (!enq_ready && n < 20) begin
            tick();
            n++;
        end
        if (!enq_ready) chk("enq_timeout", enq_ready, 1'b1);
        if (r != 5'd0 && !flush) sb_q.push_back({r, d});
        tick();
        enq_valid = 1'b0;
    endtask

    task automatic wait_empty(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (count == 6'd0) break;
            tick();
        end
        chk(tag, count, 6'd0);
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0; enq_valid = 1'b0; enq_reg = '0; enq_data = '0;
        drain_en = 1'b0; rd_reg_1 = 5'd3; rf_data_1 = 32'h1234;
        rd_reg_2 = 5'd0; rf_data_2 = 32'h77;
        tick(); tick();
        rstn = 1'b1;
        tick();

        // reset / idle
        chk("rst_count", count, 6'd0);
        chk("rst_ready", enq_ready, 1'b1);
        chk("rst_reg_write", reg_write, 1'b0);
        chk("rst_write_reg", write_reg, 5'd0);
        chk("rst_write_data", write_data, 32'd0);
        chk("idle_fwd1", fwd_data_1, 32'h1234);

        // same-cycle enqueue is not forwarded
        enq_valid = 1'b1; enq_reg = 5'd3; enq_data = 32'h99;
        #1 chk("no_same_cycle_fwd", fwd_data_1, 32'h1234);
        enq_valid = 1'b0;

        // youngest-match forwarding
        enq(5'd5, 32'hA);
        enq(5'd5, 32'hB);
        rd_reg_1 = 5'd5; rd_reg_2 = 5'd5;
        #1;
        chk("count_two", count, 6'd2);
        chk("fwd1_youngest", fwd_data_1, 32'hB);
        chk("fwd2_youngest", fwd_data_2, 32'hB);
        rd_reg_2 = 5'd6;
        #1 chk("fwd2_miss", fwd_data_2, 32'h77);
        drain_en = 1'b1;
        #1 chk("fwd_head_draining", fwd_data_1, 32'hB);
        wait_empty("drain_two_empty");
        chk("fwd1_after_drain", fwd_data_1, 32'h1234);
        drain_en = 1'b0;

        // full: ready low, request held, no look-ahead on drain
        for (int i = 1; i <= 4; i++) enq(5'(i), 32'h100 + 32'(i));
        chk("full_count", count, 6'd4);
        chk("full_ready", enq_ready, 1'b0);
        enq_valid = 1'b1; enq_reg = 5'd7; enq_data = 32'h55;
        tick(); tick();
        chk("full_held_count", count, 6'd4);
        drain_en = 1'b1;
        tick();
        enq_valid = 1'b0; drain_en = 1'b0;
        chk("full_drain_count", count, 6'd3);
        chk("full_drain_ready", enq_ready, 1'b1);
        rd_reg_1 = 5'd7;
        #1 chk("held_req_not_stored", fwd_data_1, 32'h1234);
        drain_en = 1'b1;
        wait_empty("full_drain_empty");
        drain_en = 1'b0;

        // zero register
        rd_reg_1 = 5'd0;
        enq(5'd0, 32'hFFFF);
        chk("r0_count", count, 6'd0);
        chk("r0_fwd", fwd_data_1, 32'd0);
        chk("r0_no_write", reg_write, 1'b0);

        // wrap: drain continuously while enqueuing r1..r10
        drain_en = 1'b1;
        for (int i = 1; i <= 10; i++) enq(5'(i), 32'h1000 + 32'(i));
        wait_empty("wrap_empty");
        for (int i = 1; i <= 10; i++) begin
            rd_reg_1  = 5'(i);
            rf_data_1 = 32'hCAFE_0000 + 32'(i);
            #1 chk("wrap_no_stale_fwd", fwd_data_1, 32'hCAFE_0000 + 32'(i));
        end
        drain_en = 1'b0;
        rf_data_1 = 32'h1234;

        // flush with three queued
        enq(5'd11, 32'hB1); enq(5'd12, 32'hB2); enq(5'd13, 32'hB3);
        chk("pre_flush_count", count, 6'd3);
        flush = 1'b1; drain_en = 1'b1;
        enq_valid = 1'b1; enq_reg = 5'd14; enq_data = 32'hEE;
        #1 chk("flush_no_write", reg_write, 1'b0);
        tick();
        flush = 1'b0; drain_en = 1'b0; enq_valid = 1'b0;
        sb_q.delete();
        chk("flush_count", count, 6'd0);
        rd_reg_1 = 5'd11;
        #1 chk("flush_fwd_cleared", fwd_data_1, 32'h1234);
        rd_reg_1 = 5'd14;
        #1 chk("flush_enq_discarded", fwd_data_1, 32'h1234);

        // reset mid-drain
        enq(5'd11, 32'hC1); enq(5'd12, 32'hC2); enq(5'd13, 32'hC3);
        drain_en = 1'b1;
        tick();
        rstn = 1'b0;
        #1;
        sb_q.delete();
        chk("rst_mid_count", count, 6'd0);
        chk("rst_mid_reg_write", reg_write, 1'b0);
        chk("rst_mid_write_data", write_data, 32'd0);
        chk("rst_mid_ready", enq_ready, 1'b1);
        tick();
        rstn = 1'b1; drain_en = 1'b0;
        tick();
        chk("post_rst_count", count, 6'd0);
        chk("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
